bist_fail_logger: RTL and testbench

- Downstream consumer of the MBIST wrapper's compare result.
- Each cycle the wrapper flags a miscompare during test mode, the block records:
  - the failing address
  - the March pattern index
  - the expected data
  - the actual data
- Records go into a small FIFO. The block also keeps a saturating fail count, a sticky overflow flag and a pass/fail verdict.
- A test host drains the log through a valid/ready interface after or during the test.

---
 rtl/bist_fail_logger.sv | 152 +++++++++++++++
 tb/tb_bist_fail_logger.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_fail_logger.sv
// MBIST fail logger: records miscompare events into a small FIFO drained over valid/ready,
// and keeps a saturating fail count, a sticky overflow flag and a pass/fail verdict.
// Optional first-fail capture registers are built when FIRST_FAIL_CAPTURE_EN is defined.
module bist_fail_logger #(
  parameter int size   = 6,
  parameter int length = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              session_start,
  input  logic              test_done,
  input  logic              NbarT,
  input  logic              fail,
  input  logic [2:0]        pat_idx,
  input  logic [size-1:0]   fail_addr,
  input  logic [length-1:0] exp_data,
  input  logic [length-1:0] act_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_pat,
  output logic [size-1:0]   out_addr,
  output logic [length-1:0] out_exp,
  output logic [length-1:0] out_act,
  output logic [CNT_W-1:0]  fail_count,
  output logic              overflow,
  output logic              busy,
  output logic              done,
`ifdef FIRST_FAIL_CAPTURE_EN
  output logic              first_valid,
  output logic [2:0]        first_pat,
  output logic [size-1:0]   first_addr,
`endif
  output logic              pass
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]        pat;
    logic [size-1:0]   addr;
    logic [length-1:0] exp;
    logic [length-1:0] act;
  } entry_t;

  state_t        state;
  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wr_entry;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          capture;
  logic          pop;
  logic          push;

  // Extra pointer MSB distinguishes full (wrapped) from empty when the index bits match.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    capture  = fail && NbarT && (state == CAPTURE) && !session_start;
    pop      = !empty && out_ready;
    push     = capture && (!full || pop);
    wr_entry = '{pat: pat_idx, addr: fail_addr, exp: exp_data, act: act_data};
    head     = mem[rd_ptr[AW-1:0]];
  end

  // Head fields are forced to zero while empty so unwritten storage never reaches the ports.
  always_comb begin
    out_valid = !empty;
    out_pat   = '0;
    out_addr  = '0;
    out_exp   = '0;
    out_act   = '0;
    if (!empty) begin
      out_pat  = head.pat;
      out_addr = head.addr;
      out_exp  = head.exp;
      out_act  = head.act;
    end
  end

  assign pass = done && (fail_count == '0);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (session_start) begin
      state <= CAPTURE;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (state == CAPTURE && test_done) begin
      state <= DONE;
      busy  <= 1'b0;
      done  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fail_count <= '0;
      overflow   <= 1'b0;
    end else if (session_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fail_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (capture && fail_count != '1) fail_count <= fail_count + CNT_W'(1);
      if (capture && !push)            overflow   <= 1'b1;
    end
  end

  // NOTE: log storage has no reset; pointers define validity and outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_valid <= 1'b0;
      first_pat   <= '0;
      first_addr  <= '0;
    end else if (session_start) begin
      first_valid <= 1'b0;
      first_pat   <= '0;
      first_addr  <= '0;
    end else if (capture && !first_valid) begin
      first_valid <= 1'b1;
      first_pat   <= pat_idx;
      first_addr  <= fail_addr;
    end
  end
`endif

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed self-checking bench for bist_fail_logger (DEPTH=8, CNT_W=8).
// Inputs change 1 time unit after each rising edge; outputs are checked at that point.
module tb_bist_fail_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic       session_start, test_done, NbarT, fail, out_ready;
  logic [2:0] pat_idx;
  logic [5:0] fail_addr;
  logic [7:0] exp_data, act_data;
  logic       out_valid, overflow, busy, done, pass;
  logic [2:0] out_pat;
  logic [5:0] out_addr;
  logic [7:0] out_exp, out_act, fail_count;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic       first_valid;
  logic [2:0] first_pat;
  logic [5:0] first_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bist_fail_logger #(.size(6), .length(8), .DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .session_start(session_start), .test_done(test_done),
    .NbarT(NbarT), .fail(fail), .pat_idx(pat_idx), .fail_addr(fail_addr),
    .exp_data(exp_data), .act_data(act_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_pat(out_pat), .out_addr(out_addr),
    .out_exp(out_exp), .out_act(out_act), .fail_count(fail_count),
    .overflow(overflow), .busy(busy), .done(done),
`ifdef FIRST_FAIL_CAPTURE_EN
    .first_valid(first_valid), .first_pat(first_pat), .first_addr(first_addr),
`endif
    .pass(pass)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    session_start = 1'b1;
    step();
    session_start = 1'b0;
  endtask

  task automatic set_fail(input logic [5:0] a);
    fail      = 1'b1;
    fail_addr = a;
    pat_idx   = a[2:0];
    exp_data  = {2'b00, a};
    act_data  = ~{2'b00, a};
  endtask

  initial begin
    logic [5:0] exp_addrs [8];

    rst = 1'b0; session_start = 0; test_done = 0; NbarT = 0; fail = 0; out_ready = 0;
    pat_idx = '0; fail_addr = '0; exp_data = '0; act_data = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_out_addr", out_addr, 0);
    step();
    rst = 1'b1;
    step();

    // Clean run
    NbarT = 1'b1;
    start_session();
    check("clean_busy", busy, 1);
    repeat (1024) step();
    test_done = 1'b1;
    step();
    test_done = 1'b0;
    check("clean_done", done, 1);
    check("clean_pass", pass, 1);
    check("clean_busy_low", busy, 0);
    check("clean_count", fail_count, 0);
    check("clean_out_valid", out_valid, 0);
    check("clean_overflow", overflow, 0);

    // Single fail, one-cycle latency, then pop
    start_session();
    fail = 1; pat_idx = 3; fail_addr = 6'h15; exp_data = 8'hAA; act_data = 8'hAB;
    step();
    fail = 0;
    check("single_valid", out_valid, 1);
    check("single_pat", out_pat, 3);
    check("single_addr", out_addr, 6'h15);
    check("single_exp", out_exp, 8'hAA);
    check("single_act", out_act, 8'hAB);
    check("single_count", fail_count, 1);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("first_addr", first_addr, 6'h15);
`endif
    out_ready = 1;
    step();
    out_ready = 0;
    check("single_popped", out_valid, 0);
    check("single_count_hold", fail_count, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    check("pop_empty_noeffect", out_valid, 0);

    // Overflow: 10 fails into 8 entries
    start_session();
    for (int i = 0; i < 10; i++) begin
      set_fail(6'(i));
      step();
    end
    fail = 0;
    check("ovf_count", fail_count, 10);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_drain_valid%0d", i), out_valid, 1);
      check($sformatf("ovf_drain_addr%0d", i), out_addr, i);
      check($sformatf("ovf_drain_act%0d", i), out_act, ~(32'(i)) & 32'hFF);
      out_ready = 1;
      step();
      out_ready = 0;
    end
    check("ovf_drained", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Full with simultaneous push and pop
    start_session();
    check("restart_clears_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      set_fail(6'(i));
      step();
    end
    set_fail(6'h3F);
    out_ready = 1;
    step();
    fail = 0; out_ready = 0;
    check("full_pp_overflow", overflow, 0);
    check("full_pp_count", fail_count, 9);
    check("full_pp_head", out_addr, 1);
    set_fail(6'h20);
    step();
    fail = 0;
    check("full_still_full", overflow, 1);
    exp_addrs = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'h3F};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_drain_addr%0d", i), out_addr, exp_addrs[i]);
      out_ready = 1;
      step();
      out_ready = 0;
    end
    check("full_drained", out_valid, 0);

    // Push and pop on empty
    start_session();
    set_fail(6'h11);
    out_ready = 1;
    step();
    fail = 0; out_ready = 0;
    check("empty_pp_valid", out_valid, 1);
    check("empty_pp_addr", out_addr, 6'h11);

    // Priority and NbarT gating
    set_fail(6'h05);
    session_start = 1;
    step();
    session_start = 0; fail = 0;
    check("prio_no_entry", out_valid, 0);
    check("prio_count", fail_count, 0);
    NbarT = 0;
    set_fail(6'h06);
    step();
    fail = 0; NbarT = 1;
    check("nbart_no_entry", out_valid, 0);
    check("nbart_count", fail_count, 0);

    // Fail coincident with test_done, then no capture in DONE
    set_fail(6'h2A);
    test_done = 1;
    step();
    test_done = 0;
    check("td_done", done, 1);
    check("td_captured", out_addr, 6'h2A);
    check("td_count", fail_count, 1);
    check("td_pass", pass, 0);
    step();
    fail = 0;
    check("done_no_capture", fail_count, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    check("done_drain", out_valid, 0);
    check("done_hold", done, 1);

    // Saturating counter
    start_session();
    set_fail(6'h01);
    repeat (260) step();
    fail = 0;
    check("sat_count", fail_count, 8'hFF);
    check("sat_overflow", overflow, 1);

    // Async reset mid-capture with 3 entries held
    start_session();
    for (int i = 0; i < 3; i++) begin
      set_fail(6'(i + 8));
      step();
    end
    fail = 0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_count", fail_count, 3);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("pre_rst_first_valid", first_valid, 1);
    check("pre_rst_first_addr", first_addr, 8);
`endif
    #2;
    rst = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_count", fail_count, 0);
    check("arst_busy", busy, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("arst_first_valid", first_valid, 0);
`endif
    step();
    rst = 1;
    step();
    check("post_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
